axi4l_regbank: RTL and testbench

//   Parametrised AXI4-Lite slave register bank: C_NUM_RW control registers and C_NUM_RO

---
 rtl/axi4l_regbank_if.sv | 37 +++
 rtl/axi4l_regbank.sv | 239 +++++++++++++++++++++++
 tb/tb_axi4l_regbank.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4l_regbank_if.sv
// AXI4-Lite bus bundle between an interconnect master and the register bank slave.
interface axi4l_regbank_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4l_regbank.sv
// AXI4-Lite slave register bank: C_NUM_RW control registers followed by C_NUM_RO status
// registers in word order. Independent write and read FSMs, byte-strobe writes, per-register
// write/read pulses for side effects in the surrounding block.
module axi4l_regbank #(
    parameter int unsigned              C_ADDR_WIDTH = 12,
    parameter int unsigned              C_DATA_WIDTH = 32,
    parameter int unsigned              C_NUM_RW     = 4,
    parameter int unsigned              C_NUM_RO     = 4,
    parameter logic [C_DATA_WIDTH-1:0]  C_RW_INIT    = '0
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    axi4l_regbank_if.slave                   s_axi,
    output logic [C_NUM_RW*C_DATA_WIDTH-1:0] rw_regs,
    output logic [C_NUM_RW-1:0]              rw_wr_pulse,
    input  logic [C_NUM_RO*C_DATA_WIDTH-1:0] ro_regs,
    output logic [C_NUM_RO-1:0]              ro_rd_pulse
);
    localparam int unsigned DW  = C_DATA_WIDTH;
    localparam int unsigned NB  = DW / 8;
    localparam int unsigned LSB = (DW == 64) ? 3 : 2;
    localparam int unsigned WW  = C_ADDR_WIDTH - LSB;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    if (!(DW == 32 || DW == 64)) begin : g_bad_dw
        $error("axi4l_regbank: C_DATA_WIDTH must be 32 or 64");
    end
    if (C_NUM_RW < 1 || C_NUM_RO < 1) begin : g_bad_num
        $error("axi4l_regbank: C_NUM_RW and C_NUM_RO must be at least 1");
    end
    if (C_NUM_RW + C_NUM_RO > (1 << WW)) begin : g_bad_map
        $error("axi4l_regbank: register map does not fit the address space");
    end

    typedef enum logic [2:0] {WrRst, WrIdle, WrAddr, WrData, WrResp} wr_state_e;
    typedef enum logic [1:0] {RdRst, RdIdle, RdResp} rd_state_e;

    // RW words answer OKAY, RO words SLVERR on write, everything past the map DECERR.
    function automatic logic [1:0] write_resp(input logic [WW-1:0] word);
        if (32'(word) < C_NUM_RW) begin
            return RespOkay;
        end else if (32'(word) < C_NUM_RW + C_NUM_RO) begin
            return RespSlvErr;
        end
        return RespDecErr;
    endfunction

    wr_state_e        wr_state;
    rd_state_e        rd_state;
    logic [WW-1:0]    aw_word_q;
    logic [DW-1:0]    wdata_q;
    logic [NB-1:0]    wstrb_q;
    logic [DW-1:0]    rw_q [C_NUM_RW];

    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             wr_commit;
    logic [WW-1:0]    wr_word;
    logic [DW-1:0]    wr_data;
    logic [NB-1:0]    wr_strb;
    logic [DW-1:0]    rd_data;
    logic [1:0]       rd_resp;
    logic [C_NUM_RO-1:0] rd_pulse;

    logic unused_bits;
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                           s_axi.awaddr[LSB-1:0], s_axi.araddr[LSB-1:0]};

    assign aw_hs = s_axi.awvalid & s_axi.awready;
    assign w_hs  = s_axi.wvalid & s_axi.wready;
    assign ar_hs = s_axi.arvalid & s_axi.arready;

    // Select the address/data pair that completes on this edge, whichever beat came first.
    always_comb begin
        wr_commit = 1'b0;
        wr_word   = s_axi.awaddr[C_ADDR_WIDTH-1:LSB];
        wr_data   = s_axi.wdata;
        wr_strb   = s_axi.wstrb;
        case (wr_state)
            WrIdle: wr_commit = aw_hs & w_hs;
            WrAddr: begin
                wr_commit = w_hs;
                wr_word   = aw_word_q;
            end
            WrData: begin
                wr_commit = aw_hs;
                wr_data   = wdata_q;
                wr_strb   = wstrb_q;
            end
            default: ;
        endcase
    end

    // Write channel FSM; readies and B outputs are registered alongside the state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state      <= WrRst;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= RespOkay;
            aw_word_q     <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            case (wr_state)
                WrRst: begin
                    wr_state      <= WrIdle;
                    s_axi.awready <= 1'b1;
                    s_axi.wready  <= 1'b1;
                end
                WrIdle: begin
                    if (aw_hs) aw_word_q <= s_axi.awaddr[C_ADDR_WIDTH-1:LSB];
                    if (w_hs) begin
                        wdata_q <= s_axi.wdata;
                        wstrb_q <= s_axi.wstrb;
                    end
                    if (wr_commit) begin
                        wr_state      <= WrResp;
                        s_axi.awready <= 1'b0;
                        s_axi.wready  <= 1'b0;
                        s_axi.bvalid  <= 1'b1;
                        s_axi.bresp   <= write_resp(wr_word);
                    end else if (aw_hs) begin
                        wr_state      <= WrAddr;
                        s_axi.awready <= 1'b0;
                    end else if (w_hs) begin
                        wr_state     <= WrData;
                        s_axi.wready <= 1'b0;
                    end
                end
                WrAddr, WrData: begin
                    if (wr_commit) begin
                        wr_state      <= WrResp;
                        s_axi.awready <= 1'b0;
                        s_axi.wready  <= 1'b0;
                        s_axi.bvalid  <= 1'b1;
                        s_axi.bresp   <= write_resp(wr_word);
                    end
                end
                WrResp: begin
                    if (s_axi.bready) begin
                        wr_state      <= WrIdle;
                        s_axi.bvalid  <= 1'b0;
                        s_axi.awready <= 1'b1;
                        s_axi.wready  <= 1'b1;
                    end
                end
                default: wr_state <= WrRst;
            endcase
        end
    end

    // Byte-lane update of the addressed RW register and its one-cycle write pulse.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < C_NUM_RW; i++) rw_q[i] <= C_RW_INIT;
            rw_wr_pulse <= '0;
        end else begin
            rw_wr_pulse <= '0;
            if (wr_commit) begin
                for (int unsigned i = 0; i < C_NUM_RW; i++) begin
                    if (32'(wr_word) == i) begin
                        for (int unsigned k = 0; k < NB; k++) begin
                            if (wr_strb[k]) rw_q[i][8*k +: 8] <= wr_data[8*k +: 8];
                        end
                        rw_wr_pulse[i] <= |wr_strb;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < C_NUM_RW; g++) begin : g_rw_out
        assign rw_regs[g*DW +: DW] = rw_q[g];
    end

    // Read decode; rw_q holds the pre-write value on an edge that also commits a write.
    always_comb begin
        rd_data  = '0;
        rd_resp  = RespDecErr;
        rd_pulse = '0;
        for (int unsigned i = 0; i < C_NUM_RW; i++) begin
            if (32'(s_axi.araddr[C_ADDR_WIDTH-1:LSB]) == i) begin
                rd_data = rw_q[i];
                rd_resp = RespOkay;
            end
        end
        for (int unsigned j = 0; j < C_NUM_RO; j++) begin
            if (32'(s_axi.araddr[C_ADDR_WIDTH-1:LSB]) == C_NUM_RW + j) begin
                rd_data     = ro_regs[j*DW +: DW];
                rd_resp     = RespOkay;
                rd_pulse[j] = 1'b1;
            end
        end
    end

    // Read channel FSM; R payload captured at the AR handshake and held until accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state      <= RdRst;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= RespOkay;
            ro_rd_pulse   <= '0;
        end else begin
            ro_rd_pulse <= '0;
            case (rd_state)
                RdRst: begin
                    rd_state      <= RdIdle;
                    s_axi.arready <= 1'b1;
                end
                RdIdle: begin
                    if (ar_hs) begin
                        rd_state      <= RdResp;
                        s_axi.arready <= 1'b0;
                        s_axi.rvalid  <= 1'b1;
                        s_axi.rdata   <= rd_data;
                        s_axi.rresp   <= rd_resp;
                        ro_rd_pulse   <= rd_pulse;
                    end
                end
                RdResp: begin
                    if (s_axi.rready) begin
                        rd_state      <= RdIdle;
                        s_axi.rvalid  <= 1'b0;
                        s_axi.arready <= 1'b1;
                    end
                end
                default: rd_state <= RdRst;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4l_regbank.sv
// Bench for axi4l_regbank: directed scenarios plus randomized concurrent traffic, all checked
// every cycle against a transaction-level model of the register map.
module tb_axi4l_regbank;
    localparam int unsigned AW   = 12;
    localparam int unsigned DW   = 32;
    localparam int unsigned NRW  = 4;
    localparam int unsigned NRO  = 4;
    localparam logic [31:0] INIT = 32'h5A5A_0F0F;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NRW*DW-1:0] rw_regs;
    logic [NRW-1:0]    rw_wr_pulse;
    logic [NRO*DW-1:0] ro_regs;
    logic [NRO-1:0]    ro_rd_pulse;
    logic              ro_rand = 1'b0;

    axi4l_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4l_regbank #(
        .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_NUM_RW(NRW), .C_NUM_RO(NRO), .C_RW_INIT(INIT)
    ) dut (
        .aclk(clk), .aresetn(rst_n), .s_axi(bus), .rw_regs(rw_regs),
        .rw_wr_pulse(rw_wr_pulse), .ro_regs(ro_regs), .ro_rd_pulse(ro_rd_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: register contents, pending beats and responses owed to the master.
    logic [31:0] m_rw [NRW];
    logic [11:0] aw_q[$];
    logic [35:0] w_q[$];
    logic [1:0]  b_q[$];
    logic [33:0] r_q[$];
    logic [3:0]  exp_wp = '0;
    logic [3:0]  exp_rp = '0;
    logic [3:0]  last_wp = '0;
    logic [3:0]  last_rp = '0;
    int          rp_cycles = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] resp_of(input int w, input bit is_write);
        if (w < NRW) return 2'b00;
        if (w < NRW + NRO) return is_write ? 2'b10 : 2'b00;
        return 2'b11;
    endfunction

    // Compare outputs against the model, then advance the model by the coming edge's handshakes.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NRW; i++) m_rw[i] = INIT;
            aw_q.delete(); w_q.delete(); b_q.delete(); r_q.delete();
            exp_wp = '0;
            exp_rp = '0;
            check("rst_bvalid", bus.bvalid, 0);
            check("rst_rvalid", bus.rvalid, 0);
            check("rst_pulses", {rw_wr_pulse, ro_rd_pulse}, 0);
            for (int i = 0; i < NRW; i++)
                check($sformatf("rst_rw_regs[%0d]", i), rw_regs[i*DW +: DW], INIT);
        end else begin
            for (int i = 0; i < NRW; i++)
                check($sformatf("rw_regs[%0d]", i), rw_regs[i*DW +: DW], m_rw[i]);
            check("rw_wr_pulse", rw_wr_pulse, exp_wp);
            check("ro_rd_pulse", ro_rd_pulse, exp_rp);
            check("bvalid", bus.bvalid, b_q.size() != 0);
            if (bus.bvalid && b_q.size() != 0) check("bresp", bus.bresp, b_q[0]);
            check("rvalid", bus.rvalid, r_q.size() != 0);
            if (bus.rvalid && r_q.size() != 0) begin
                check("rdata", bus.rdata, r_q[0][31:0]);
                check("rresp", bus.rresp, r_q[0][33:32]);
            end
            if (rw_wr_pulse != 0) last_wp = rw_wr_pulse;
            if (ro_rd_pulse != 0) begin
                last_rp = ro_rd_pulse;
                rp_cycles++;
            end

            exp_wp = '0;
            exp_rp = '0;
            if (bus.bvalid && bus.bready && b_q.size() != 0) void'(b_q.pop_front());
            if (bus.rvalid && bus.rready && r_q.size() != 0) void'(r_q.pop_front());
            if (bus.arvalid && bus.arready) begin
                int w;
                logic [31:0] d;
                w = int'(bus.araddr[11:2]);
                d = '0;
                if (w < NRW) d = m_rw[w];
                else if (w < NRW + NRO) begin
                    d = ro_regs[(w-NRW)*DW +: DW];
                    exp_rp[w-NRW] = 1'b1;
                end
                r_q.push_back({resp_of(w, 1'b0), d});
            end
            if (bus.awvalid && bus.awready) aw_q.push_back(bus.awaddr);
            if (bus.wvalid && bus.wready) w_q.push_back({bus.wstrb, bus.wdata});
            if (aw_q.size() != 0 && w_q.size() != 0) begin
                int w;
                logic [35:0] sd;
                w  = int'(aw_q[0][11:2]);
                sd = w_q.pop_front();
                void'(aw_q.pop_front());
                if (w < NRW) begin
                    for (int k = 0; k < 4; k++)
                        if (sd[32+k]) m_rw[w][8*k +: 8] = sd[8*k +: 8];
                    if (sd[35:32] != 0) exp_wp[w] = 1'b1;
                end
                b_q.push_back(resp_of(w, 1'b1));
            end
        end
    end

    always @(posedge clk) begin
        if (ro_rand) begin
            #1;
            for (int j = 0; j < NRO; j++) ro_regs[j*DW +: DW] = $urandom();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input logic [11:0] a, input int dly);
        bit hs = 1'b0;
        repeat (dly) tick();
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        for (int n = 0; n < 64 && !hs; n++) begin
            @(negedge clk);
            hs = bus.awready;
            tick();
        end
        bus.awvalid = 1'b0;
        check("aw_handshake", hs, 1);
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        bit hs = 1'b0;
        repeat (dly) tick();
        bus.wdata  = d;
        bus.wstrb  = s;
        bus.wvalid = 1'b1;
        for (int n = 0; n < 64 && !hs; n++) begin
            @(negedge clk);
            hs = bus.wready;
            tick();
        end
        bus.wvalid = 1'b0;
        check("w_handshake", hs, 1);
    endtask

    task automatic do_b(input int dly, output logic [1:0] resp);
        bit hs = 1'b0;
        resp = 2'bxx;
        repeat (dly) tick();
        bus.bready = 1'b1;
        for (int n = 0; n < 64 && !hs; n++) begin
            @(negedge clk);
            hs = bus.bvalid;
            if (hs) resp = bus.bresp;
            tick();
        end
        bus.bready = 1'b0;
        check("b_handshake", hs, 1);
    endtask

    task automatic do_ar(input logic [11:0] a, input int dly);
        bit hs = 1'b0;
        repeat (dly) tick();
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        for (int n = 0; n < 64 && !hs; n++) begin
            @(negedge clk);
            hs = bus.arready;
            tick();
        end
        bus.arvalid = 1'b0;
        check("ar_handshake", hs, 1);
    endtask

    task automatic do_r(input int dly, output logic [31:0] d, output logic [1:0] resp);
        bit hs = 1'b0;
        d    = 'x;
        resp = 2'bxx;
        repeat (dly) tick();
        bus.rready = 1'b1;
        for (int n = 0; n < 64 && !hs; n++) begin
            @(negedge clk);
            hs = bus.rvalid;
            if (hs) begin
                d    = bus.rdata;
                resp = bus.rresp;
            end
            tick();
        end
        bus.rready = 1'b0;
        check("r_handshake", hs, 1);
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp);
        fork
            do_aw(a, aw_dly);
            do_w(d, s, w_dly);
        join
        do_b(b_dly, resp);
    endtask

    task automatic axi_read(input logic [11:0] a, input int ar_dly, input int r_dly,
                            output logic [31:0] d, output logic [1:0] resp);
        do_ar(a, ar_dly);
        do_r(r_dly, d, resp);
    endtask

    function automatic logic [11:0] rand_addr();
        logic [9:0]  w;
        int unsigned p;
        p = $urandom_range(0, 19);
        w = (p == 0) ? 10'h3FF : 10'(p % 12);
        return {w, 2'($urandom_range(0, 3))};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  resp;
        logic [1:0]  resp2;
        logic [31:0] d;

        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        ro_regs = '0;

        // Reset release: readies rise one cycle after the first edge.
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_ready_first_cycle", {bus.awready, bus.wready, bus.arready}, 3'b000);
        tick();
        @(negedge clk);
        check("t1_ready_after", {bus.awready, bus.wready, bus.arready}, 3'b111);
        check("t1_reg0_init", rw_regs[31:0], 32'h5A5A_0F0F);
        tick();

        // Full write with AW and W together.
        last_wp = '0;
        axi_write(12'h004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp);
        check("t2_bresp", resp, 2'b00);
        check("t2_reg1", rw_regs[63:32], 32'hDEAD_BEEF);
        check("t2_pulse", last_wp, 4'b0010);

        // W leads AW by three cycles, low half-word strobe.
        axi_write(12'h000, 32'hAAAA_AAAA, 4'hF, 0, 0, 0, resp);
        last_wp = '0;
        axi_write(12'h000, 32'h0000_1234, 4'h3, 3, 0, 1, resp);
        check("t3_bresp", resp, 2'b00);
        check("t3_reg0", rw_regs[31:0], 32'hAAAA_1234);
        check("t3_pulse", last_wp, 4'b0001);

        // Zero strobe: OKAY, no change, no pulse.
        last_wp = '0;
        axi_write(12'h004, 32'h0BAD_0BAD, 4'h0, 0, 2, 0, resp);
        check("strb0_bresp", resp, 2'b00);
        check("strb0_reg1", rw_regs[63:32], 32'hDEAD_BEEF);
        check("strb0_pulse", last_wp, 4'b0000);

        // Error responses.
        axi_write(12'h010, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp);
        check("t4_ro_bresp", resp, 2'b10);
        check("t4_ro_reg0", rw_regs[31:0], 32'hAAAA_1234);
        axi_write(12'hFFC, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, resp);
        check("t4_unmapped_bresp", resp, 2'b11);
        axi_read(12'hFFC, 0, 0, d, resp);
        check("t4_unmapped_rdata", d, 32'h0);
        check("t4_unmapped_rresp", resp, 2'b11);

        // RO read held for five cycles while the source changes underneath.
        ro_regs[63:32] = 32'h55;
        last_rp = '0;
        rp_cycles = 0;
        do_ar(12'h014, 0);
        tick();
        ro_regs[63:32] = 32'h66;
        do_r(4, d, resp);
        check("t5_rdata", d, 32'h55);
        check("t5_rresp", resp, 2'b00);
        check("t5_pulse", last_rp, 4'b0010);
        check("t5_pulse_cycles", rp_cycles, 1);

        // Read and write of the same RW register on one edge: read sees the old value.
        axi_write(12'h008, 32'h1111_1111, 4'hF, 0, 0, 0, resp);
        fork
            axi_write(12'h008, 32'h2222_2222, 4'hF, 0, 0, 0, resp);
            axi_read(12'h008, 0, 0, d, resp2);
        join
        check("rw_same_rdata", d, 32'h1111_1111);
        check("rw_same_reg2", rw_regs[95:64], 32'h2222_2222);

        // Reset with a write waiting for W.
        do_aw(12'h00C, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6a_bvalid", bus.bvalid, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        do_w(32'h7777_7777, 4'hF, 0);
        repeat (3) tick();
        check("t6a_no_stale_b", bus.bvalid, 0);
        do_aw(12'h004, 0);
        do_b(0, resp);
        check("t6a_bresp", resp, 2'b00);

        // Reset with both a write and a read response outstanding.
        fork
            do_aw(12'h008, 0);
            do_w(32'h3333_3333, 4'hF, 0);
            do_ar(12'h018, 0);
        join
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("t6b_bvalid", bus.bvalid, 0);
        check("t6b_rvalid", bus.rvalid, 0);
        check("t6b_reg2", rw_regs[95:64], INIT);
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("t6b_no_stale", {bus.bvalid, bus.rvalid}, 2'b00);

        // Randomized concurrent traffic with changing RO sources.
        ro_rand = 1'b1;
        fork
            begin
                for (int t = 0; t < 150; t++) begin
                    logic [1:0] r;
                    axi_write(rand_addr(), $urandom(), 4'($urandom_range(0, 15)),
                              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                              int'($urandom_range(0, 2)), r);
                end
            end
            begin
                for (int t = 0; t < 150; t++) begin
                    logic [31:0] rd;
                    logic [1:0]  r;
                    axi_read(rand_addr(), int'($urandom_range(0, 3)),
                             int'($urandom_range(0, 3)), rd, r);
                end
            end
        join
        ro_rand = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
